// File: rtl/roi_harness_pkg.sv
// Shared definitions for the ROI harness serial-port driver.
package roi_harness_pkg;

    localparam int DIN_N_DEF  = 256;
    localparam int DOUT_N_DEF = 256;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STB,
        CAPT,
        DONE
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/roi_shift_driver_shifter.sv
// Parameterized shift register: parallel load, left shift with serial in,
// serial out from the MSB, and the would-be next value for same-edge capture.
module piso_sipo_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] par_in,
    input  logic         si,
    output logic         so,
    output logic [W-1:0] par_out,
    output logic [W-1:0] shift_nxt
);

    logic [W-1:0] sr;

    // A one-bit register has nothing to keep when it shifts.
    generate
        if (W == 1) begin : g_w1
            assign shift_nxt = si;
        end else begin : g_wn
            assign shift_nxt = {sr[W-2:0], si};
        end
    endgenerate

    assign so      = sr[W-1];
    assign par_out = sr;

    // Load has priority over shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr <= '0;
        else if (load)
            sr <= par_in;
        else if (shift_en)
            sr <= shift_nxt;
    end

endmodule

// File: rtl/roi_shift_driver.sv
// Host-side master for the ROI harness serial port: shifts a stimulus
// vector in on ser_di, strobes, then shifts the dout snapshot back on ser_do.
module roi_shift_driver
    import roi_harness_pkg::*;
#(
    parameter int DIN_N  = DIN_N_DEF,
    parameter int DOUT_N = DOUT_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DIN_N-1:0]  req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DOUT_N-1:0] rsp_data,
    output logic              ser_di,
    output logic              ser_stb,
    input  logic              ser_do,
    output logic              busy
);

    localparam int CNT_W = $clog2(max2(DIN_N, DOUT_N) + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               cnt_last;
    logic               capt_en;
    logic               tx_so;
    logic [DIN_N-1:0]   tx_par;
    logic [DIN_N-1:0]   tx_nxt;
    logic               rx_so;
    logic [DOUT_N-1:0]  rx_par;
    logic [DOUT_N-1:0]  rx_nxt;
    logic               unused_ok;

    assign accept   = (state == IDLE) && req_valid && req_ready;
    // Treat 0 as terminal too so a stray zero count can never wrap.
    assign cnt_last = (cnt <= CNT_W'(1));
    // ser_stb is still high on the first CAPT edge; harness do is only
    // valid from the edge after that, so the first CAPT edge is skipped.
    assign capt_en  = (state == CAPT) && !ser_stb;

    assign unused_ok = &{1'b0, tx_par, tx_nxt, rx_so, rx_par};

    piso_sipo_shifter #(.W(DIN_N)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift_en  (state == SHIFT),
        .par_in    (req_data),
        .si        (1'b0),
        .so        (tx_so),
        .par_out   (tx_par),
        .shift_nxt (tx_nxt)
    );

    piso_sipo_shifter #(.W(DOUT_N)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift_en  (capt_en),
        .par_in    ('0),
        .si        (ser_do),
        .so        (rx_so),
        .par_out   (rx_par),
        .shift_nxt (rx_nxt)
    );

    // Transaction sequencer; every port output is a register of this block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ser_di    <= 1'b0;
            ser_stb   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        cnt       <= CNT_W'(DIN_N);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    ser_di <= tx_so;
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                    if (cnt_last)
                        state <= STB;
                end
                STB: begin
                    ser_di  <= 1'b0;
                    ser_stb <= 1'b1;
                    cnt     <= CNT_W'(DOUT_N);
                    state   <= CAPT;
                end
                CAPT: begin
                    ser_stb <= 1'b0;
                    if (!ser_stb) begin
                        if (cnt != '0)
                            cnt <= cnt - CNT_W'(1);
                        if (cnt_last) begin
                            rsp_data  <= rx_nxt;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_roi_shift_driver.sv
// Bench for roi_shift_driver: three drivers (8/8, 256/256, 1/1) each talking
// to a behavioural harness; responses checked against a scoreboard.
module tb_roi_shift_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- 8/8 driver, harness dout = ~din ----------------
    logic       d8_req_valid = 1'b0, d8_rsp_ready = 1'b0;
    logic [7:0] d8_req_data = '0;
    logic       d8_req_ready, d8_rsp_valid, d8_ser_di, d8_ser_stb, d8_ser_do, d8_busy;
    logic [7:0] d8_rsp_data;
    logic [7:0] h8_din_shr, h8_din, h8_dout_shr;

    roi_shift_driver #(.DIN_N(8), .DOUT_N(8)) u_d8 (
        .clk(clk), .rst(rst),
        .req_valid(d8_req_valid), .req_ready(d8_req_ready), .req_data(d8_req_data),
        .rsp_valid(d8_rsp_valid), .rsp_ready(d8_rsp_ready), .rsp_data(d8_rsp_data),
        .ser_di(d8_ser_di), .ser_stb(d8_ser_stb), .ser_do(d8_ser_do), .busy(d8_busy)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h8_din_shr <= '0; h8_din <= '0; h8_dout_shr <= '0;
        end else begin
            h8_din_shr <= {h8_din_shr[6:0], d8_ser_di};
            if (d8_ser_stb) begin
                h8_din      <= h8_din_shr;
                h8_dout_shr <= ~h8_din;
            end else begin
                h8_dout_shr <= {h8_dout_shr[6:0], 1'b0};
            end
        end
    end
    assign d8_ser_do = h8_dout_shr[7];

    // ---------------- 256/256 driver, harness dout = din ----------------
    logic         d256_req_valid = 1'b0, d256_rsp_ready = 1'b0;
    logic [255:0] d256_req_data = '0;
    logic         d256_req_ready, d256_rsp_valid, d256_ser_di, d256_ser_stb, d256_ser_do, d256_busy;
    logic [255:0] d256_rsp_data;
    logic [255:0] h256_din_shr, h256_din, h256_dout_shr;

    roi_shift_driver #(.DIN_N(256), .DOUT_N(256)) u_d256 (
        .clk(clk), .rst(rst),
        .req_valid(d256_req_valid), .req_ready(d256_req_ready), .req_data(d256_req_data),
        .rsp_valid(d256_rsp_valid), .rsp_ready(d256_rsp_ready), .rsp_data(d256_rsp_data),
        .ser_di(d256_ser_di), .ser_stb(d256_ser_stb), .ser_do(d256_ser_do), .busy(d256_busy)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h256_din_shr <= '0; h256_din <= '0; h256_dout_shr <= '0;
        end else begin
            h256_din_shr <= {h256_din_shr[254:0], d256_ser_di};
            if (d256_ser_stb) begin
                h256_din      <= h256_din_shr;
                h256_dout_shr <= h256_din;
            end else begin
                h256_dout_shr <= {h256_dout_shr[254:0], 1'b0};
            end
        end
    end
    assign d256_ser_do = h256_dout_shr[255];

    // ---------------- 1/1 driver, harness dout = ~din ----------------
    logic       d1_req_valid = 1'b0, d1_rsp_ready = 1'b0;
    logic [0:0] d1_req_data = '0;
    logic       d1_req_ready, d1_rsp_valid, d1_ser_di, d1_ser_stb, d1_ser_do, d1_busy;
    logic [0:0] d1_rsp_data;
    logic       h1_din_shr, h1_din, h1_dout_shr;

    roi_shift_driver #(.DIN_N(1), .DOUT_N(1)) u_d1 (
        .clk(clk), .rst(rst),
        .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_data(d1_req_data),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_data(d1_rsp_data),
        .ser_di(d1_ser_di), .ser_stb(d1_ser_stb), .ser_do(d1_ser_do), .busy(d1_busy)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_din_shr <= 1'b0; h1_din <= 1'b0; h1_dout_shr <= 1'b0;
        end else begin
            h1_din_shr <= d1_ser_di;
            if (d1_ser_stb) begin
                h1_din      <= h1_din_shr;
                h1_dout_shr <= ~h1_din;
            end else begin
                h1_dout_shr <= 1'b0;
            end
        end
    end
    assign d1_ser_do = h1_dout_shr;

    // ---------------- scoreboards and reference state ----------------
    // m*_din tracks what the harness din register holds after each strobe.
    logic [7:0]   exp8_q[$];
    logic [255:0] exp256_q[$];
    logic         exp1_q[$];
    logic [7:0]   m8_din   = '0;
    logic [255:0] m256_din = '0;
    logic         m1_din   = 1'b0;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        d8_req_valid = 0; d256_req_valid = 0; d1_req_valid = 0;
        d8_rsp_ready = 0; d256_rsp_ready = 0; d1_rsp_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m8_din = '0; m256_din = '0; m1_din = 1'b0;
        exp8_q.delete(); exp256_q.delete(); exp1_q.delete();
    endtask

    // Offer one vector to the 8-bit driver and watch until rsp_valid;
    // returns latency (-1 on timeout), observed ser_di bits and strobe info.
    task automatic run8(input logic [7:0] vec, output int lat, output logic [7:0] di_seq,
                        output int stb_cnt, output int stb_pos);
        lat = -1; di_seq = '0; stb_cnt = 0; stb_pos = -1;
        @(negedge clk);
        d8_req_valid = 1'b1; d8_req_data = vec;
        exp8_q.push_back(~m8_din);
        m8_din = vec;
        @(negedge clk);
        d8_req_valid = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (cyc <= 8) di_seq[8-cyc] = d8_ser_di;
            if (d8_ser_stb) begin stb_cnt++; stb_pos = cyc; end
            if (d8_rsp_valid) begin lat = cyc; break; end
        end
    endtask

    task automatic take8();
        d8_rsp_ready = 1'b1;
        @(negedge clk);
        d8_rsp_ready = 1'b0;
    endtask

    task automatic run256(input logic [255:0] vec, output int lat);
        lat = -1;
        @(negedge clk);
        d256_req_valid = 1'b1; d256_req_data = vec;
        exp256_q.push_back(m256_din);
        m256_din = vec;
        @(negedge clk);
        d256_req_valid = 1'b0;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(negedge clk);
            if (d256_rsp_valid) begin lat = cyc; break; end
        end
    endtask

    task automatic run1(input logic vec, output int lat, output int stb_pos);
        lat = -1; stb_pos = -1;
        @(negedge clk);
        d1_req_valid = 1'b1; d1_req_data = vec;
        exp1_q.push_back(~m1_din);
        m1_din = vec;
        @(negedge clk);
        d1_req_valid = 1'b0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (d1_ser_stb) stb_pos = cyc;
            if (d1_rsp_valid) begin lat = cyc; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_total++; if (d8_req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", d8_req_ready); else n_pass++;
        n_total++; if (d8_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", d8_busy); else n_pass++;
        n_total++; if (d8_ser_di !== 1'b0) $display("FAIL reset_ser_di got=%b exp=0", d8_ser_di); else n_pass++;
        n_total++; if (d8_ser_stb !== 1'b0) $display("FAIL reset_ser_stb got=%b exp=0", d8_ser_stb); else n_pass++;
        n_total++; if (d8_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", d8_rsp_valid); else n_pass++;
        n_total++; if (d8_rsp_data !== 8'h00) $display("FAIL reset_rsp_data got=%h exp=00", d8_rsp_data); else n_pass++;
        n_total++; if (d256_req_ready !== 1'b1) $display("FAIL reset_req_ready_256 got=%b exp=1", d256_req_ready); else n_pass++;
        n_total++; if (d1_req_ready !== 1'b1) $display("FAIL reset_req_ready_1 got=%b exp=1", d1_req_ready); else n_pass++;
    endtask

    task automatic test_serial();
        int lat, sc, sp;
        logic [7:0] seq, exp;
        do_reset();
        run8(8'hA5, lat, seq, sc, sp);
        n_total++; if (seq !== 8'b1010_0101) $display("FAIL serial_di_seq got=%b exp=10100101", seq); else n_pass++;
        n_total++; if (sc !== 1) $display("FAIL serial_stb_count got=%0d exp=1", sc); else n_pass++;
        n_total++; if (sp !== 9) $display("FAIL serial_stb_cycle got=%0d exp=9", sp); else n_pass++;
        exp = exp8_q.pop_front();
        n_total++; if (d8_rsp_data !== exp) $display("FAIL serial_rsp got=%h exp=%h", d8_rsp_data, exp); else n_pass++;
        take8();
    endtask

    task automatic test_back_to_back();
        int lat, sc, sp;
        logic [7:0] seq, exp;
        do_reset();
        run8(8'hA5, lat, seq, sc, sp);
        n_total++; if (lat !== 18) $display("FAIL b2b_lat1 got=%0d exp=18", lat); else n_pass++;
        exp = exp8_q.pop_front();
        n_total++; if (d8_rsp_data !== exp) $display("FAIL b2b_rsp1 got=%h exp=%h", d8_rsp_data, exp); else n_pass++;
        take8();
        run8(8'h3C, lat, seq, sc, sp);
        n_total++; if (lat !== 18) $display("FAIL b2b_lat2 got=%0d exp=18", lat); else n_pass++;
        exp = exp8_q.pop_front();
        n_total++; if (d8_rsp_data !== exp) $display("FAIL b2b_rsp2 got=%h exp=%h", d8_rsp_data, exp); else n_pass++;
        take8();
    endtask

    task automatic test_hold_done();
        int lat, sc, sp;
        int bad_data = 0, bad_ready = 0, bad_stb = 0, bad_valid = 0, bad_idle = 0;
        logic [7:0] seq, exp, held;
        run8(8'hC3, lat, seq, sc, sp);
        held = d8_rsp_data;
        for (int i = 0; i < 20; i++) begin
            d8_req_valid = (i % 2 == 0);
            d8_req_data  = 8'($urandom);
            @(negedge clk);
            if (d8_rsp_data !== held) bad_data++;
            if (d8_req_ready !== 1'b0) bad_ready++;
            if (d8_ser_stb !== 1'b0) bad_stb++;
            if (d8_rsp_valid !== 1'b1) bad_valid++;
        end
        d8_req_valid = 1'b0;
        n_total++; if (bad_data != 0) $display("FAIL hold_rsp_data unstable=%0d exp=0", bad_data); else n_pass++;
        n_total++; if (bad_ready != 0) $display("FAIL hold_req_ready high=%0d exp=0", bad_ready); else n_pass++;
        n_total++; if (bad_stb != 0) $display("FAIL hold_ser_stb high=%0d exp=0", bad_stb); else n_pass++;
        n_total++; if (bad_valid != 0) $display("FAIL hold_rsp_valid low=%0d exp=0", bad_valid); else n_pass++;
        exp = exp8_q.pop_front();
        n_total++; if (held !== exp) $display("FAIL hold_rsp got=%h exp=%h", held, exp); else n_pass++;
        take8();
        // rsp_ready with nothing held must not disturb IDLE
        d8_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (d8_rsp_valid !== 1'b0 || d8_req_ready !== 1'b1 || d8_busy !== 1'b0) bad_idle++;
        end
        d8_rsp_ready = 1'b0;
        n_total++; if (bad_idle != 0) $display("FAIL idle_rsp_ready disturbed=%0d exp=0", bad_idle); else n_pass++;
        // the ignored pulses must not have reached the harness
        run8(8'h00, lat, seq, sc, sp);
        n_total++; if (lat !== 18) $display("FAIL hold_next_lat got=%0d exp=18", lat); else n_pass++;
        exp = exp8_q.pop_front();
        n_total++; if (d8_rsp_data !== exp) $display("FAIL hold_next_rsp got=%h exp=%h", d8_rsp_data, exp); else n_pass++;
        take8();
    endtask

    task automatic test_reset_abort();
        int lat, sc, sp;
        int stb_seen = 0;
        logic di_before;
        logic [7:0] seq, exp;
        do_reset();
        @(negedge clk);
        d8_req_valid = 1'b1; d8_req_data = 8'hFF;
        @(negedge clk);
        d8_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (d8_ser_stb) stb_seen++;
        end
        di_before = d8_ser_di;
        n_total++; if (d8_busy !== 1'b1 || di_before !== 1'b1)
            $display("FAIL abort_mid_shift busy=%b di=%b exp=1,1", d8_busy, di_before); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (d8_ser_di !== 1'b0) $display("FAIL abort_ser_di got=%b exp=0", d8_ser_di); else n_pass++;
        n_total++; if (d8_busy !== 1'b0 || d8_req_ready !== 1'b1)
            $display("FAIL abort_busy_ready got=%b%b exp=01", d8_busy, d8_req_ready); else n_pass++;
        n_total++; if (d8_rsp_valid !== 1'b0 || d8_rsp_data !== 8'h00)
            $display("FAIL abort_rsp got=%b/%h exp=0/00", d8_rsp_valid, d8_rsp_data); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        m8_din = '0;
        exp8_q.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (d8_ser_stb) stb_seen++;
        end
        n_total++; if (stb_seen != 0) $display("FAIL abort_no_stb got=%0d exp=0", stb_seen); else n_pass++;
        run8(8'h5A, lat, seq, sc, sp);
        n_total++; if (lat !== 18 || sc !== 1) $display("FAIL abort_next lat=%0d stb=%0d exp=18,1", lat, sc); else n_pass++;
        exp = exp8_q.pop_front();
        n_total++; if (d8_rsp_data !== exp) $display("FAIL abort_next_rsp got=%h exp=%h", d8_rsp_data, exp); else n_pass++;
        take8();
    endtask

    task automatic test_wide();
        int lat;
        logic [255:0] v1, v2, exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v1[i*32 +: 32] = $urandom;
            v2[i*32 +: 32] = $urandom;
        end
        run256(v1, lat);
        n_total++; if (lat !== 514) $display("FAIL wide_lat1 got=%0d exp=514", lat); else n_pass++;
        exp = exp256_q.pop_front();
        n_total++; if (d256_rsp_data !== exp) $display("FAIL wide_rsp1 got=%h exp=%h", d256_rsp_data, exp); else n_pass++;
        d256_rsp_ready = 1'b1; @(negedge clk); d256_rsp_ready = 1'b0;
        run256(v2, lat);
        n_total++; if (lat !== 514) $display("FAIL wide_lat2 got=%0d exp=514", lat); else n_pass++;
        exp = exp256_q.pop_front();
        n_total++; if (d256_rsp_data !== exp) $display("FAIL wide_rsp2 got=%h exp=%h", d256_rsp_data, exp); else n_pass++;
        d256_rsp_ready = 1'b1; @(negedge clk); d256_rsp_ready = 1'b0;
    endtask

    task automatic test_narrow();
        int lat, sp;
        logic exp;
        logic [2:0] vecs;
        vecs = 3'b101;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run1(vecs[i], lat, sp);
            n_total++; if (lat !== 4) $display("FAIL narrow_lat%0d got=%0d exp=4", i, lat); else n_pass++;
            n_total++; if (sp !== 2) $display("FAIL narrow_stb%0d got=%0d exp=2", i, sp); else n_pass++;
            exp = exp1_q.pop_front();
            n_total++; if (d1_rsp_data[0] !== exp) $display("FAIL narrow_rsp%0d got=%b exp=%b", i, d1_rsp_data[0], exp); else n_pass++;
            d1_rsp_ready = 1'b1; @(negedge clk); d1_rsp_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_serial();
        test_back_to_back();
        test_hold_done();
        test_reset_abort();
        test_wide();
        test_narrow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/roi_shift_driver.md
Name: roi_shift_driver

Overview:
- Host-side master for the ROI harness serial port (di/stb in, do out).
- Shifts a DIN_N-bit stimulus vector into the harness input shift register, then pulses stb. The pulse loads the harness din register and snapshots ROI dout into the harness output shift register.
- Then shifts the DOUT_N-bit snapshot back out through do and presents it as a parallel response.
- Sits between a stimulus source (bench, or a fuzzer-vector ROM) and the harness top.

Parameters:
- DIN_N, 256: width of the stimulus vector; must equal the harness DIN_N.
- DOUT_N, 256: width of the response vector; must equal the harness DOUT_N.
- CNT_W, $clog2(max(DIN_N,DOUT_N)+1): width of the bit counter; derived, not overridden.

Ports:
- clk  in  1  single clock, shared with the harness.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  stimulus vector offered.
- req_ready  out  1  driver can accept a vector (high only in IDLE).
- req_data  in  DIN_N  stimulus vector.
- rsp_valid  out  1  response vector held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DOUT_N  captured harness dout snapshot.
- ser_di  out  1  to harness di.
- ser_stb  out  1  to harness stb.
- ser_do  in  1  from harness do.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, counter=0, shift regs=0.
  - ser_di=0, ser_stb=0, rsp_valid=0, rsp_data=0, req_ready=1, busy=0.
- All outputs are registered; ser_di and ser_stb change only on clk edges.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_data into tx_sr, counter=DIN_N, go SHIFT.
- SHIFT:
  - Each cycle ser_di = tx_sr[DIN_N-1] (MSB first); tx_sr shifts left; counter decrements.
  - Exactly DIN_N cycles of ser_di are driven, so harness din_shr[k] == req_data[k].
  - After the last bit go STB.
- STB:
  - ser_stb=1 and ser_di=0 for exactly one cycle.
  - The harness captures din<=din_shr and dout_shr<=dout on this edge.
  - Load counter=DOUT_N, go CAPT.
- CAPT:
  - ser_stb=0, ser_di=0.
  - Sample ser_do on each of DOUT_N consecutive edges, the first being the edge after the STB cycle.
  - rx_sr <= {rx_sr[DOUT_N-2:0], ser_do}.
  - After DOUT_N samples rx_sr == harness dout at the strobe edge.
  - Copy to rsp_data, set rsp_valid=1, go DONE.
- DONE:
  - rsp_data and rsp_valid are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, go IDLE.
  - req_ready stays 0, so there is no overlap between transactions.
- Transaction latency, from the req accept edge to rsp_valid rising: DIN_N+1+DOUT_N+1 cycles (514 at defaults).
- Semantics:
  - The response reflects ROI dout as driven by the harness din loaded at the previous strobe.
  - A stimulus vector's own effect appears in the next transaction's response.
  - A reset mid-SHIFT or mid-CAPT aborts without a strobe; no partial response is presented.
- Boundaries:
  - req_valid in non-IDLE states is ignored; data is not latched.
  - rsp_ready while rsp_valid=0 has no effect.
  - Counter terminal value 0 must not underflow.
  - DIN_N or DOUT_N = 1 must work: one SHIFT cycle / one CAPT cycle.

Decomposition:
- Shared package roi_harness_pkg:
  - constants DIN_N_DEF=256, DOUT_N_DEF=256.
  - state enum {IDLE, SHIFT, STB, CAPT, DONE}.
- One natural sub-module, piso_sipo_shifter: a parameterized shift register with load, shift-enable, serial in/out and parallel in/out. Instantiate it twice (tx and rx).

Test Plan:
- Bench model: a behavioural harness top with DIN_N=DOUT_N=8 and ROI dout = ~din.
- Test 1: reset, then req_data=8'hA5 → ser_di sequence 1,0,1,0,0,1,0,1; ser_stb high exactly one cycle, on the cycle after the 8th bit.
- Test 2: two transactions, A5 then 3C → first rsp_data=8'hFF (~reset din 00); second rsp_data=8'h5A; rsp_valid rises 18 cycles after each req accept.
- Test 3: hold rsp_ready=0 for 20 cycles in DONE → rsp_data stable; req_ready=0; req_valid pulses ignored; ser_stb stays 0.
- Test 4: assert rst at cycle 4 of SHIFT → ser_stb is never pulsed; all outputs return to reset values the same cycle; the next transaction completes normally.
- Test 5: DIN_N=DOUT_N=256, random vector with a dout=din loopback model → second transaction's rsp_data equals the first vector bit-for-bit; latency 514.
- Test 6: DIN_N=1, DOUT_N=1, ROI dout = ~din → strobe follows a single SHIFT cycle; capture completes after a single sample; rsp_valid rises 4 cycles after accept.
